// File: rtl/ysyx_25030093_wbu_if.sv
// Write-back unit bus: upstream retire request, register/CSR file write ports,
// trap update and the next-PC handoff to the fetch unit.
interface ysyx_25030093_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_dnpc;
  logic [ADDR_WIDTH-1:0] in_rd_addr;
  logic [DATA_WIDTH-1:0] in_rd_data;
  logic                  in_rd_wen;
  logic [11:0]           in_csr_addr;
  logic [DATA_WIDTH-1:0] in_csr_wdata;
  logic                  in_csr_wen;
  logic                  in_ecall;
  logic                  in_mret;
  logic [DATA_WIDTH-1:0] csr_mtvec;
  logic [DATA_WIDTH-1:0] csr_mepc;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  rf_wen;
  logic [11:0]           csr_waddr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  csr_wen;
  logic                  trap_wen;
  logic [DATA_WIDTH-1:0] trap_mepc;
  logic [DATA_WIDTH-1:0] trap_mcause;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_npc;
  logic [63:0]           instret;

  modport slave (
    input  in_valid, in_pc, in_dnpc, in_rd_addr, in_rd_data, in_rd_wen,
           in_csr_addr, in_csr_wdata, in_csr_wen, in_ecall, in_mret,
           csr_mtvec, csr_mepc, out_ready,
    output in_ready, rf_waddr, rf_wdata, rf_wen, csr_waddr, csr_wdata, csr_wen,
           trap_wen, trap_mepc, trap_mcause, out_valid, out_npc, instret
  );

  modport master (
    output in_valid, in_pc, in_dnpc, in_rd_addr, in_rd_data, in_rd_wen,
           in_csr_addr, in_csr_wdata, in_csr_wen, in_ecall, in_mret,
           csr_mtvec, csr_mepc, out_ready,
    input  in_ready, rf_waddr, rf_wdata, rf_wen, csr_waddr, csr_wdata, csr_wen,
           trap_wen, trap_mepc, trap_mcause, out_valid, out_npc, instret
  );
endinterface

// File: rtl/ysyx_25030093_wbu.sv
// Write-back unit: latches one retiring instruction, commits its GPR/CSR/trap
// writes for a single cycle, then hands the next PC to the fetch unit.
module ysyx_25030093_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_25030093_wbu_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMMIT  = 2'd1;
  localparam logic [1:0] HANDOFF = 2'd2;

  localparam logic [DATA_WIDTH-1:0] MCAUSE_ECALL_M = DATA_WIDTH'(11);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] dnpc_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_wen_q;
  logic [11:0]           csr_addr_q;
  logic [DATA_WIDTH-1:0] csr_wdata_q;
  logic                  csr_wen_q;
  logic                  ecall_q;
  logic                  mret_q;
  logic [DATA_WIDTH-1:0] npc_q, npc_d;
  logic [63:0]           instret_q;

  logic accept;
  logic handoff;
  logic in_commit;

  // Outputs are masked while rst is high so a pending commit/handoff is
  // discarded in the very cycle reset is asserted.
  assign in_commit = (state_q == COMMIT) && !rst;
  assign accept    = (state_q == IDLE) && !rst && bus.in_valid;
  assign handoff   = (state_q == HANDOFF) && !rst && bus.out_ready;

  assign bus.in_ready    = (state_q == IDLE) && !rst;
  assign bus.out_valid   = (state_q == HANDOFF) && !rst;
  assign bus.out_npc     = npc_q;
  assign bus.instret     = instret_q;

  assign bus.rf_waddr    = rd_addr_q;
  assign bus.rf_wdata    = rd_data_q;
  assign bus.rf_wen      = in_commit && rd_wen_q && (rd_addr_q != '0) && !ecall_q;
  assign bus.csr_waddr   = csr_addr_q;
  assign bus.csr_wdata   = csr_wdata_q;
  assign bus.csr_wen     = in_commit && csr_wen_q && !ecall_q;
  assign bus.trap_wen    = in_commit && ecall_q;
  assign bus.trap_mepc   = pc_q;
  assign bus.trap_mcause = MCAUSE_ECALL_M;

  // ecall takes precedence when both trap entry and return are flagged
  always_comb begin
    npc_d = dnpc_q;
    if (ecall_q)     npc_d = bus.csr_mtvec;
    else if (mret_q) npc_d = bus.csr_mepc;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = COMMIT;
      COMMIT:  state_d = HANDOFF;
      HANDOFF: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      dnpc_q      <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_wen_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wen_q   <= 1'b0;
      ecall_q     <= 1'b0;
      mret_q      <= 1'b0;
      npc_q       <= '0;
      instret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q        <= bus.in_pc;
        dnpc_q      <= bus.in_dnpc;
        rd_addr_q   <= bus.in_rd_addr;
        rd_data_q   <= bus.in_rd_data;
        rd_wen_q    <= bus.in_rd_wen;
        csr_addr_q  <= bus.in_csr_addr;
        csr_wdata_q <= bus.in_csr_wdata;
        csr_wen_q   <= bus.in_csr_wen;
        ecall_q     <= bus.in_ecall;
        mret_q      <= bus.in_mret;
      end
      if (in_commit) npc_q <= npc_d;
      if (handoff)   instret_q <= instret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_wbu.sv
// Scoreboard bench for the write-back unit: directed retire requests push
// expected write/trap/handoff events; a negedge monitor pops and compares.
module tb_ysyx_25030093_wbu;

  localparam int K_RF   = 0;
  localparam int K_CSR  = 1;
  localparam int K_TRAP = 2;
  localparam int K_HO   = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ev_t  expq[$];
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_instret = '0;

  ysyx_25030093_wbu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ysyx_25030093_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void expect_ev(int k, logic [31:0] a, logic [31:0] b, logic [63:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    expq.push_back(e);
  endfunction

  task automatic match(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] c, input string name);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event: got a=%h b=%h c=%h, required none", name, a, b, c);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b || e.c !== c) begin
        errors++;
        $display("FAIL %s got kind=%0d a=%h b=%h c=%h, required kind=%0d a=%h b=%h c=%h",
                 name, k, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.rf_wen === 1'b1)
      match(K_RF, {27'b0, bus.rf_waddr}, bus.rf_wdata, 64'd0, "rf_write");
    if (bus.csr_wen === 1'b1)
      match(K_CSR, {20'b0, bus.csr_waddr}, bus.csr_wdata, 64'd0, "csr_write");
    if (bus.trap_wen === 1'b1)
      match(K_TRAP, bus.trap_mepc, bus.trap_mcause, 64'd0, "trap");
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      match(K_HO, bus.out_npc, 32'd0, bus.instret, "handoff");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] dnpc,
                       input logic [4:0] rd, input logic [31:0] rdata, input logic rwen,
                       input logic [11:0] caddr, input logic [31:0] cwdata, input logic cwen,
                       input logic ecall, input logic mret);
    @(posedge clk); #1;
    chk("in_ready_before_issue", {63'd0, bus.in_ready}, 64'd1);
    bus.in_pc = pc; bus.in_dnpc = dnpc; bus.in_rd_addr = rd; bus.in_rd_data = rdata;
    bus.in_rd_wen = rwen; bus.in_csr_addr = caddr; bus.in_csr_wdata = cwdata;
    bus.in_csr_wen = cwen; bus.in_ecall = ecall; bus.in_mret = mret;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid !== 1'b1) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_handoff();
    wait_out_valid();
    @(posedge clk); #1;
    exp_instret = exp_instret + 64'd1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
    @(negedge clk);
    chk("post_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("post_reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("post_reset_instret", bus.instret, 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_dnpc = '0; bus.in_rd_addr = '0;
    bus.in_rd_data = '0; bus.in_rd_wen = 1'b0; bus.in_csr_addr = '0;
    bus.in_csr_wdata = '0; bus.in_csr_wen = 1'b0; bus.in_ecall = 1'b0;
    bus.in_mret = 1'b0; bus.out_ready = 1'b1;
    bus.csr_mtvec = 32'h8000_0100; bus.csr_mepc = 32'h8000_0014;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_instret", bus.instret, 64'd0);

    // plain GPR write
    expect_ev(K_RF, 32'd5, 32'hDEAD_BEEF, 64'd0);
    expect_ev(K_HO, 32'h8000_0004, 32'd0, 64'd0);
    issue(32'h8000_0000, 32'h8000_0004, 5'd5, 32'hDEAD_BEEF, 1'b1, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_handoff();
    @(negedge clk);
    chk("instret_after_first", bus.instret, 64'd1);

    // x0 write suppressed
    expect_ev(K_HO, 32'h8000_0008, 32'd0, 64'd1);
    issue(32'h8000_0004, 32'h8000_0008, 5'd0, 32'h1111_1111, 1'b1, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_handoff();

    // GPR + CSR write together
    expect_ev(K_RF, 32'd3, 32'd7, 64'd0);
    expect_ev(K_CSR, 32'h341, 32'h0000_1234, 64'd0);
    expect_ev(K_HO, 32'h8000_000C, 32'd0, 64'd2);
    issue(32'h8000_0008, 32'h8000_000C, 5'd3, 32'd7, 1'b1, 12'h341, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    wait_handoff();

    // ecall suppresses GPR/CSR writes and redirects to mtvec
    expect_ev(K_TRAP, 32'h8000_0010, 32'd11, 64'd0);
    expect_ev(K_HO, 32'h8000_0100, 32'd0, 64'd3);
    issue(32'h8000_0010, 32'h8000_0014, 5'd4, 32'h4444_4444, 1'b1, 12'h305, 32'h5555_5555, 1'b1, 1'b1, 1'b0);
    wait_handoff();

    // mret returns to mepc without a trap update
    expect_ev(K_HO, 32'h8000_0014, 32'd0, 64'd4);
    issue(32'h8000_0100, 32'h8000_0104, 5'd0, 32'd0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_handoff();

    // ecall and mret together behave as ecall
    expect_ev(K_TRAP, 32'h8000_0020, 32'd11, 64'd0);
    expect_ev(K_HO, 32'h8000_0100, 32'd0, 64'd5);
    issue(32'h8000_0020, 32'h8000_0024, 5'd0, 32'd0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b1, 1'b1);
    wait_handoff();

    // backpressure: handoff held, second request ignored
    expect_ev(K_RF, 32'd6, 32'h0000_0055, 64'd0);
    expect_ev(K_HO, 32'h8000_0028, 32'd0, 64'd6);
    bus.out_ready = 1'b0;
    issue(32'h8000_0024, 32'h8000_0028, 5'd6, 32'h0000_0055, 1'b1, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_out_valid();
    bus.in_pc = 32'h9000_0000; bus.in_dnpc = 32'h9000_0004; bus.in_rd_addr = 5'd9;
    bus.in_rd_data = 32'h0000_0BAD; bus.in_rd_wen = 1'b1; bus.in_ecall = 1'b0;
    bus.in_mret = 1'b0; bus.in_csr_wen = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_out_npc", {32'd0, bus.out_npc}, {32'd0, 32'h8000_0028});
      chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_handoff();
    @(negedge clk);
    chk("instret_after_hold", bus.instret, 64'd7);

    // reset while in HANDOFF: GPR write already committed, handoff discarded
    expect_ev(K_RF, 32'd7, 32'h0000_0077, 64'd0);
    bus.out_ready = 1'b0;
    issue(32'h8000_0028, 32'h8000_002C, 5'd7, 32'h0000_0077, 1'b1, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_out_valid();
    do_reset();
    bus.out_ready = 1'b1;

    // reset while in COMMIT: no write at all
    issue(32'h8000_0030, 32'h8000_0034, 5'd8, 32'h0000_0088, 1'b1, 12'h300, 32'h8, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
    @(negedge clk);
    chk("commit_reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("commit_reset_instret", bus.instret, 64'd0);

    // normal operation resumes after reset
    expect_ev(K_RF, 32'd1, 32'h0000_00A5, 64'd0);
    expect_ev(K_HO, 32'h0000_0100, 32'd0, 64'd0);
    issue(32'h0000_00FC, 32'h0000_0100, 5'd1, 32'h0000_00A5, 1'b1, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0);
    wait_handoff();
    @(negedge clk);
    chk("instret_final", bus.instret, exp_instret);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
